mem_stage_ctrl: RTL and testbench
=================================

// Module: mem_stage_ctrl
// PURPOSE
//  Sequences data-bus transactions for LW/LH/LB/SW/SH/SB in the M stage.
//  Sits between the M pipeline register and the data bus (dreq/dresp).
//  Stalls the pipeline until the access completes, then presents aligned,
//  extended load data to writeback. A watchdog flags a bus that never answers.
// PARAMETERS
//  TIMEOUT  255  cycles in REQ+WAIT before bus_err; 0 disables the watchdog
// PORTS
//  clk            in   1   clock; all state updates on posedge
//  reset          in   1   synchronous, active-high reset
//  m_valid        in   1   M stage holds a real instruction (not a bubble)
//  m_load         in   1   instruction is a load
//  m_store        in   1   instruction is a store
//  m_size         in   2   0=byte 1=half 2=word; 3 is illegal, treated as misaligned
//  m_sext         in   1   sign-extend load result (LB/LH); ignored for word
//  m_addr         in   32  effective address
//  m_wdata        in   32  store data, right-aligned
//  pipe_advance   in   1   downstream accepts the M-stage result this cycle
//  dreq_valid     out  1   bus request valid
//  dreq_addr      out  32  request address, word-aligned (m_addr[31:2],2'b00)
//  dreq_strobe    out  4   byte write enables; 0 for loads
//  dreq_wdata     out  32  store data shifted into byte lanes
//  dresp_addr_ok  in   1   bus accepted the request this cycle
//  dresp_data_ok  in   1   bus returns data / write done this cycle
//  dresp_data     in   32  raw read word
//  m_stall        out  1   hold F/D/E/M registers
//  m_done         out  1   access complete; m_rdata valid
//  m_rdata        out  32  extracted, extended load data (0 for stores)
//  misalign_err   out  1   address not aligned to m_size; no bus access made
//  bus_err        out  1   watchdog expired
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; dreq_* regs and watchdog counter cleared.
//  mem_op = m_valid & (m_load | m_store). Stall = mem_op & state != DONE.
//  Alignment: half needs addr[0]=0; word needs addr[1:0]=0.
//  States and transitions:
//   IDLE: mem_op & aligned -> REQ, latch addr/strobe/wdata/size/sext.
//         mem_op & misaligned -> DONE with misalign_err=1 (no dreq_valid).
//   REQ : dreq_valid=1, fields held stable. addr_ok&data_ok -> DONE, latch data.
//         addr_ok only -> WAIT.
//   WAIT: dreq_valid=0. data_ok -> DONE, latch dresp_data.
//   DONE: m_done=1, m_stall=0, m_rdata/err flags held. pipe_advance -> IDLE.
//  Minimum latency: request 1 cycle after the op is seen; m_done the cycle
//   after data_ok, so best case 2 cycles of stall.
//  Strobes: byte 4'b0001<<addr[1:0]; half 4'b0011<<{addr[1],1'b0}; word 4'hF.
//   Store data: byte replicated x4; half replicated x2; word as is.
//  Load extract: select lane by addr[1:0], zero- or sign-extend by m_sext.
//  Watchdog: counts each cycle in REQ/WAIT and clears on entry to REQ.
//   At TIMEOUT -> DONE with bus_err=1, m_rdata=0. Counter width $clog2(TIMEOUT+1).
//  Flags misalign_err/bus_err clear on leaving DONE.
//  Reset mid-access: return to IDLE immediately and drop dreq_valid.
//   A late data_ok after reset, or data_ok while in IDLE, is ignored.
//  m_valid=0 (bubble) in IDLE: no action, no stall.
// TESTING
//  LW 0x100, bus addr_ok+data_ok same cycle, data 0xDEADBEEF
//   -> dreq_strobe=0; m_done after 2 cycles; m_rdata=0xDEADBEEF.
//  LB sext addr 0x103, data 0x80FF_FF7F -> m_rdata=0xFFFF_FF80;
//   same with LBU -> m_rdata=0x0000_0080.
//  SH addr 0x102, wdata 0x1234
//   -> dreq_strobe=4'b1100, dreq_wdata=0x1234_1234, dreq_addr=0x100.
//  addr_ok delayed 3 cycles, data_ok 2 cycles later
//   -> dreq_valid stays high with stable fields; m_stall high until DONE.
//  LW addr 0x102 -> no dreq_valid; next cycle m_done=1, misalign_err=1.
//  TIMEOUT=4, bus never responds -> bus_err=1 at DONE.
//  Reset asserted in WAIT -> IDLE next cycle; following data_ok is ignored.

Source files
------------

// File: rtl/mem_stage_ctrl_if.sv
// Data-bus handshake between the M-stage controller (master) and the memory port (slave).
interface mem_stage_ctrl_if;
    logic        dreq_valid;
    logic [31:0] dreq_addr;
    logic [3:0]  dreq_strobe;
    logic [31:0] dreq_wdata;
    logic        dresp_addr_ok;
    logic        dresp_data_ok;
    logic [31:0] dresp_data;

    modport master (
        output dreq_valid, dreq_addr, dreq_strobe, dreq_wdata,
        input  dresp_addr_ok, dresp_data_ok, dresp_data
    );

    modport slave (
        input  dreq_valid, dreq_addr, dreq_strobe, dreq_wdata,
        output dresp_addr_ok, dresp_data_ok, dresp_data
    );
endinterface

// File: rtl/mem_stage_ctrl.sv
// M-stage load/store sequencer: issues one bus access per memory op, stalls the
// pipe until it completes, and returns aligned, extended load data.
//
// state | meaning
// IDLE  | no access in flight; waiting for a memory op
// REQ   | dreq_valid high, waiting for the bus to accept the address
// WAIT  | address accepted, waiting for read data / write completion
// DONE  | result (or error flag) presented until the pipe advances
module mem_stage_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m_valid,
    input  logic              m_load,
    input  logic              m_store,
    input  logic [1:0]        m_size,
    input  logic              m_sext,
    input  logic [31:0]       m_addr,
    input  logic [31:0]       m_wdata,
    input  logic              pipe_advance,
    mem_stage_ctrl_if.master  bus,
    output logic              m_stall,
    output logic              m_done,
    output logic [31:0]       m_rdata,
    output logic              misalign_err,
    output logic              bus_err
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] WD_LOAD = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t          state;
    logic [CW-1:0]   wd_cnt;
    logic            wd_expired;
    logic            lat_load;
    logic            lat_sext;
    logic [1:0]      lat_size;
    logic [1:0]      lat_off;

    logic            mem_op;
    logic            aligned;
    logic [3:0]      strobe_c;
    logic [31:0]     wdata_c;
    logic [31:0]     shifted;
    logic [31:0]     load_val;

    assign mem_op     = m_valid & (m_load | m_store);
    assign m_stall    = mem_op & (state != S_DONE);
    assign wd_expired = (TIMEOUT != 0) && (wd_cnt == '0);

    always_comb begin
        aligned  = 1'b0;
        strobe_c = 4'hF;
        wdata_c  = m_wdata;
        case (m_size)
            2'd0: begin
                aligned  = 1'b1;
                strobe_c = 4'b0001 << m_addr[1:0];
                wdata_c  = {4{m_wdata[7:0]}};
            end
            2'd1: begin
                aligned  = ~m_addr[0];
                strobe_c = 4'b0011 << {m_addr[1], 1'b0};
                wdata_c  = {2{m_wdata[15:0]}};
            end
            2'd2: aligned = (m_addr[1:0] == 2'b00);
            default: aligned = 1'b0;
        endcase
    end

    // Lane extraction works straight off the bus so data is captured the cycle data_ok arrives.
    always_comb begin
        shifted  = bus.dresp_data >> {lat_off, 3'b000};
        load_val = 32'h0;
        if (lat_load) begin
            case (lat_size)
                2'd0:    load_val = {{24{lat_sext & shifted[7]}}, shifted[7:0]};
                2'd1:    load_val = {{16{lat_sext & shifted[15]}}, shifted[15:0]};
                default: load_val = bus.dresp_data;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= S_IDLE;
            wd_cnt          <= '0;
            lat_load        <= 1'b0;
            lat_sext        <= 1'b0;
            lat_size        <= 2'd0;
            lat_off         <= 2'd0;
            bus.dreq_valid  <= 1'b0;
            bus.dreq_addr   <= 32'h0;
            bus.dreq_strobe <= 4'h0;
            bus.dreq_wdata  <= 32'h0;
            m_done          <= 1'b0;
            m_rdata         <= 32'h0;
            misalign_err    <= 1'b0;
            bus_err         <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (mem_op) begin
                        if (aligned) begin
                            state           <= S_REQ;
                            wd_cnt          <= WD_LOAD;
                            lat_load        <= m_load;
                            lat_sext        <= m_sext;
                            lat_size        <= m_size;
                            lat_off         <= m_addr[1:0];
                            bus.dreq_valid  <= 1'b1;
                            bus.dreq_addr   <= {m_addr[31:2], 2'b00};
                            bus.dreq_strobe <= m_store ? strobe_c : 4'h0;
                            bus.dreq_wdata  <= wdata_c;
                        end else begin
                            state        <= S_DONE;
                            m_done       <= 1'b1;
                            m_rdata      <= 32'h0;
                            misalign_err <= 1'b1;
                        end
                    end
                end
                S_REQ: begin
                    if (bus.dresp_addr_ok && bus.dresp_data_ok) begin
                        state          <= S_DONE;
                        bus.dreq_valid <= 1'b0;
                        m_done         <= 1'b1;
                        m_rdata        <= load_val;
                    end else if (wd_expired) begin
                        state          <= S_DONE;
                        bus.dreq_valid <= 1'b0;
                        m_done         <= 1'b1;
                        m_rdata        <= 32'h0;
                        bus_err        <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt - 1'b1;
                        if (bus.dresp_addr_ok) begin
                            state          <= S_WAIT;
                            bus.dreq_valid <= 1'b0;
                        end
                    end
                end
                S_WAIT: begin
                    if (bus.dresp_data_ok) begin
                        state   <= S_DONE;
                        m_done  <= 1'b1;
                        m_rdata <= load_val;
                    end else if (wd_expired) begin
                        state   <= S_DONE;
                        m_done  <= 1'b1;
                        m_rdata <= 32'h0;
                        bus_err <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    if (pipe_advance) begin
                        state        <= S_IDLE;
                        m_done       <= 1'b0;
                        m_rdata      <= 32'h0;
                        misalign_err <= 1'b0;
                        bus_err      <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Randomised bench for mem_stage_ctrl against a transaction-level reference model.
module tb_mem_stage_ctrl;
    localparam int T = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        m_valid, m_load, m_store, m_sext, pipe_advance;
    logic [1:0]  m_size;
    logic [31:0] m_addr, m_wdata;
    logic        m_stall, m_done, misalign_err, bus_err;
    logic [31:0] m_rdata;

    mem_stage_ctrl_if bus ();

    mem_stage_ctrl #(.TIMEOUT(T)) dut (
        .clk          (clk),
        .reset        (reset),
        .m_valid      (m_valid),
        .m_load       (m_load),
        .m_store      (m_store),
        .m_size       (m_size),
        .m_sext       (m_sext),
        .m_addr       (m_addr),
        .m_wdata      (m_wdata),
        .pipe_advance (pipe_advance),
        .bus          (bus),
        .m_stall      (m_stall),
        .m_done       (m_done),
        .m_rdata      (m_rdata),
        .misalign_err (misalign_err),
        .bus_err      (bus_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_resp();
        bus.dresp_addr_ok = 1'b0;
        bus.dresp_data_ok = 1'b0;
        bus.dresp_data    = 32'h0;
    endtask

    // One memory op. a = REQ cycles before addr_ok, d = cycles from addr_ok to data_ok.
    task automatic run_op(input bit ld, input logic [1:0] sz, input bit sx,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] rd, input int a, input int d, input int hold);
        int nb, k, exp_stall, stalls, reqc, waitc, sh_bits;
        bit al, berr, accepted, done, hold_bad;
        logic [3:0]  es;
        logic [31:0] ew, er, sh, mask, ea;

        nb = (sz == 2'd3) ? 0 : (1 << sz);
        al = 1'b0;
        if (nb != 0) al = ((addr % nb) == 0);
        k    = a + 1 + d;
        berr = al && (k > T);
        ea   = addr & ~32'h3;
        es   = 4'h0;
        ew   = 32'h0;
        er   = 32'h0;
        if (al) begin
            if (!ld) es = 4'(((1 << nb) - 1) << (addr % 4));
            for (int i = 0; i < 4; i++) ew[8*i +: 8] = wd[8*(i % nb) +: 8];
            if (ld && !berr) begin
                sh_bits = 8 * int'(addr % 4);
                sh   = rd >> sh_bits;
                mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nb)) - 1);
                er   = sh & mask;
                if (sx && nb < 4 && sh[8*nb-1]) er = er | ~mask;
            end
        end
        exp_stall = al ? (((k > T) ? T : k) + 1) : 1;

        @(posedge clk); #1;
        m_valid = 1'b1; m_load = ld; m_store = !ld;
        m_size = sz; m_sext = sx; m_addr = addr; m_wdata = wd;
        pipe_advance = 1'b0;

        stalls = 0; reqc = 0; waitc = 0; accepted = 0; done = 0; hold_bad = 0;
        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge clk);
            clear_resp();
            if (m_done) begin
                done = 1;
            end else begin
                if (m_stall) stalls++;
                if (bus.dreq_valid) begin
                    if (accepted) hold_bad = 1;
                    if (bus.dreq_addr !== ea || bus.dreq_strobe !== es) hold_bad = 1;
                    if (!ld && bus.dreq_wdata !== ew) hold_bad = 1;
                    if (reqc == a) begin
                        bus.dresp_addr_ok = 1'b1;
                        accepted = 1;
                        if (d == 0) begin
                            bus.dresp_data_ok = 1'b1;
                            bus.dresp_data    = rd;
                        end
                    end
                    reqc++;
                end else if (accepted) begin
                    waitc++;
                    if (waitc == d) begin
                        bus.dresp_data_ok = 1'b1;
                        bus.dresp_data    = rd;
                    end
                end
            end
        end

        check("done_seen", 32'(done), 32'd1);
        check("stall_cycles", 32'(stalls), 32'(exp_stall));
        check("req_issued", 32'(reqc > 0), 32'(al));
        check("dreq_fields", 32'(hold_bad), 32'd0);
        check("m_stall_done", 32'(m_stall), 32'd0);
        check("misalign_err", 32'(misalign_err), 32'(!al));
        check("bus_err", 32'(bus_err), 32'(berr));
        check("m_rdata", m_rdata, er);

        for (int h = 0; h < hold; h++) @(negedge clk);
        if (hold > 0) check("done_held", {m_done, misalign_err, bus_err}, {1'b1, !al, berr});
        pipe_advance = 1'b1;
        @(posedge clk); #1;
        pipe_advance = 1'b0;
        m_valid = 1'b0;
        @(negedge clk);
        check("flags_cleared", {m_done, misalign_err, bus_err, m_stall, bus.dreq_valid}, 5'b0);
    endtask

    initial begin
        reset = 1'b1;
        m_valid = 0; m_load = 0; m_store = 0; m_sext = 0; m_size = 0;
        m_addr = 0; m_wdata = 0; pipe_advance = 0;
        clear_resp();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ctrl", {m_stall, m_done, misalign_err, bus_err, bus.dreq_valid}, 5'b0);
        check("rst_rdata", m_rdata, 32'h0);
        check("rst_daddr", bus.dreq_addr, 32'h0);
        check("rst_strobe", 32'(bus.dreq_strobe), 32'h0);
        check("rst_wdata", bus.dreq_wdata, 32'h0);
        reset = 1'b0;

        run_op(1, 2'd2, 0, 32'h100, 32'h0, 32'hDEAD_BEEF, 0, 0, 0);
        run_op(1, 2'd0, 1, 32'h103, 32'h0, 32'h80FF_FF7F, 0, 0, 1);
        run_op(1, 2'd0, 0, 32'h103, 32'h0, 32'h80FF_FF7F, 0, 0, 0);
        run_op(0, 2'd1, 0, 32'h102, 32'h1234, 32'h0, 1, 1, 0);
        run_op(1, 2'd2, 0, 32'h204, 32'h0, 32'h1357_9BDF, 3, 2, 2);
        run_op(1, 2'd2, 0, 32'h102, 32'h0, 32'h0, 0, 0, 1);
        run_op(1, 2'd3, 0, 32'h100, 32'h0, 32'h0, 0, 0, 0);
        run_op(1, 2'd1, 1, 32'h302, 32'h0, 32'h8001_0000, 1000, 0, 1);
        run_op(0, 2'd2, 0, 32'h400, 32'hCAFE_F00D, 32'h0, 2, 1000, 0);

        // Reset during WAIT, then a stale data_ok must not complete anything.
        @(posedge clk); #1;
        m_valid = 1; m_load = 1; m_store = 0; m_size = 2'd2; m_addr = 32'h500;
        @(negedge clk);
        @(negedge clk);
        check("rst_req_valid", 32'(bus.dreq_valid), 32'd1);
        bus.dresp_addr_ok = 1'b1;
        @(negedge clk);
        clear_resp();
        check("rst_wait_valid", 32'(bus.dreq_valid), 32'd0);
        reset = 1'b1; m_valid = 0;
        @(negedge clk);
        check("rst_mid_idle", {bus.dreq_valid, m_done, m_stall}, 3'b0);
        reset = 1'b0;
        bus.dresp_data_ok = 1'b1; bus.dresp_data = 32'hFFFF_FFFF;
        @(negedge clk);
        clear_resp();
        check("late_data_ignored", {m_done, m_stall, bus.dreq_valid, bus_err}, 4'b0);
        check("late_rdata", m_rdata, 32'h0);

        for (int n = 0; n < 60; n++) begin
            int a, d;
            logic [31:0] addr;
            a = $urandom_range(0, 5);
            d = $urandom_range(0, 4);
            if (a + 1 + d == T) d++;
            if ($urandom_range(0, 9) == 0) a = 1000;
            addr = $urandom;
            run_op(1'($urandom), 2'($urandom), 1'($urandom), addr, $urandom, $urandom,
                   a, d, $urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1, "bench timeout");
    end

endmodule
